// File: rtl/ocm_stream_if.sv
// Valid/ready stream carrying 64-bit memory words toward the SERDES datapath.
// The last flag marks the final word of a pass.
interface ocm_stream_if #(
  parameter int unsigned DATA_W = 64
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/ocm_stream_reader.sv
// Reads a programmed window of the 64-bit on-chip memory port in address order and streams
// the words out through a small prefetch FIFO; optional looping until stopped.
module ocm_stream_reader #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MEM_WORDS  = 8960,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_en_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] length_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       pass_count_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_chipsel_o,
  output logic              mem_clken_o,
  input  logic [DATA_W-1:0] mem_readdata_i,
  ocm_stream_if.master      out_if
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFlush} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, addr_q, addr_d, base_q, base_d, len_q, len_d;
  logic              loop_q, loop_d, done_q, done_d;
  logic [15:0]       pass_q, pass_d;
  logic              inflight_q, inflight_last_q;
  logic              issue, last_issue, push, pop, flush;

  logic [DATA_W:0]   fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q;

  // RUN always has words left: the FSM leaves RUN on the cycle the last word is issued.
  assign issue      = (state_q == StRun) && ((32'(cnt_q) + 32'(inflight_q)) < FIFO_DEPTH);
  assign last_issue = issue && (idx_q == len_q - ADDR_W'(1));
  assign flush      = (state_q == StFlush);
  assign push       = inflight_q && !flush;
  assign pop        = out_if.valid && out_if.ready;

  assign out_if.valid  = (cnt_q != '0) && !flush;
  assign out_if.data   = fifo_q[rd_ptr_q][DATA_W-1:0];
  assign out_if.last   = fifo_q[rd_ptr_q][DATA_W] && out_if.valid;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign pass_count_o  = pass_q;
  assign mem_address_o = addr_q;
  assign mem_chipsel_o = issue;
  assign mem_clken_o   = 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    base_d  = base_q;
    len_d   = len_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    if (pop && out_if.last && (pass_q != 16'hFFFF)) begin
      pass_d = pass_q + 16'd1;
    end
    unique case (state_q)
      StIdle: begin
        if (start_i && !stop_i) begin
          base_d = base_addr_i;
          len_d  = length_i;
          loop_d = loop_en_i;
          pass_d = 16'd0;
          if (length_i != '0) begin
            state_d = StRun;
            idx_d   = '0;
            addr_d  = base_addr_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (stop_i) begin
          state_d = StFlush;
        end else if (last_issue) begin
          if (loop_q) begin
            idx_d  = '0;
            addr_d = base_q;
          end else begin
            state_d = StDrain;
          end
        end else if (issue) begin
          idx_d  = idx_q + ADDR_W'(1);
          addr_d = (addr_q == ADDR_W'(MEM_WORDS - 1)) ? '0 : addr_q + ADDR_W'(1);
        end
      end
      StDrain: begin
        if (stop_i) begin
          state_d = StFlush;
        end else if ((cnt_q == '0) && !inflight_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StFlush: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      addr_q          <= '0;
      base_q          <= '0;
      len_q           <= '0;
      loop_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 16'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      addr_q          <= addr_d;
      base_q          <= base_d;
      len_q           <= len_d;
      loop_q          <= loop_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
    end
  end

  // Issue rule keeps count+inflight <= depth, so a push never lands on a full FIFO.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {inflight_last_q, mem_readdata_i};
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end
endmodule

// File: tb/tb_ocm_stream_reader.sv
// Directed bench for ocm_stream_reader with a behavioural registered-address memory model.
module tb_ocm_stream_reader;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [13:0] base_addr = '0, length = '0;
  logic        busy, done, mem_chipsel, mem_clken;
  logic [15:0] pass_count;
  logic [13:0] mem_address, mem_addr_q = '0;
  logic [63:0] mem_readdata;
  int          tests = 0, fails = 0;

  logic        r_cs [32], r_valid [32], r_last [32], r_done [32], r_busy [32];
  logic [13:0] r_addr [32];
  logic [63:0] r_data [32];

  ocm_stream_if #(.DATA_W(64)) sif ();

  ocm_stream_reader dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .stop_i(stop), .loop_en_i(loop_en),
    .base_addr_i(base_addr), .length_i(length), .busy_o(busy), .done_o(done),
    .pass_count_o(pass_count), .mem_address_o(mem_address), .mem_chipsel_o(mem_chipsel),
    .mem_clken_o(mem_clken), .mem_readdata_i(mem_readdata), .out_if(sif.master)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mdata(input logic [13:0] a);
    return {16'hC0DE, 34'd0, a};
  endfunction

  always @(posedge clk) mem_addr_q <= mem_address;
  assign mem_readdata = mdata(mem_addr_q);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; leaves the bench in the first cycle after start is latched.
  task automatic start_pass(input logic [13:0] b, input logic [13:0] l, input logic lp,
                            input logic st);
    base_addr = b; length = l; loop_en = lp; start = 1'b1; stop = st;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic record(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      r_cs[k] = mem_chipsel; r_addr[k] = mem_address; r_valid[k] = sif.valid;
      r_data[k] = sif.data; r_last[k] = sif.last; r_done[k] = done; r_busy[k] = busy;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int got, bad, over, issued, accepted, lasts, dseen, ncs, nval, nbusy, ndone;
    logic seen_last;
    logic [13:0] t2a [4];
    t2a[0] = 14'd8958; t2a[1] = 14'd8959; t2a[2] = 14'd0; t2a[3] = 14'd1;
    sif.ready = 1'b0;

    // Reset values
    #12;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_valid", sif.valid, 0);
    chk("rst_last", sif.last, 0); chk("rst_cs", mem_chipsel, 0);
    chk("rst_addr", mem_address, 0); chk("rst_pass", pass_count, 0);
    chk("rst_data", sif.data, 0); chk("rst_clken", mem_clken, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // T1: base 10, length 4
    sif.ready = 1'b1;
    start_pass(14'd10, 14'd4, 1'b0, 1'b0);
    record(10);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_cs%0d", k), r_cs[k], 1);
      chk($sformatf("t1_addr%0d", k), r_addr[k], 10 + k);
      chk($sformatf("t1_valid%0d", k + 2), r_valid[k + 2], 1);
      chk($sformatf("t1_data%0d", k + 2), r_data[k + 2], mdata(14'(10 + k)));
      chk($sformatf("t1_last%0d", k + 2), r_last[k + 2], (k == 3) ? 1 : 0);
    end
    chk("t1_cs4", r_cs[4], 0); chk("t1_valid1", r_valid[1], 0);
    chk("t1_valid6", r_valid[6], 0); chk("t1_done6", r_done[6], 0);
    chk("t1_done7", r_done[7], 1); chk("t1_done8", r_done[8], 0);
    chk("t1_busy6", r_busy[6], 1); chk("t1_busy7", r_busy[7], 0);
    chk("t1_pass", pass_count, 1);

    // T2: window wraps across the end of memory
    start_pass(14'd8958, 14'd4, 1'b0, 1'b0);
    record(10);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_addr%0d", k), r_addr[k], t2a[k]);
      chk($sformatf("t2_data%0d", k + 2), r_data[k + 2], mdata(t2a[k]));
    end
    chk("t2_done", r_done[7], 1); chk("t2_pass", pass_count, 1);

    // T3: backpressure, then irregular ready
    sif.ready = 1'b0;
    start_pass(14'd100, 14'd6, 1'b0, 1'b0);
    record(20);
    ncs = 0;
    for (int k = 0; k < 20; k++) ncs += int'(r_cs[k]);
    chk("t3_issued_held", ncs, 4);
    chk("t3_cs3", r_cs[3], 1);
    chk("t3_valid_held", r_valid[19], 1);
    chk("t3_data_held", r_data[19], mdata(14'd100));
    got = 0; bad = 0; over = 0; issued = 4; accepted = 0; seen_last = 1'b0;
    for (int k = 0; k < 100 && !seen_last; k++) begin
      sif.ready = (k % 3 != 1);
      @(negedge clk);
      if (mem_chipsel) begin
        if (issued - accepted >= 4) over++;
        issued++;
      end
      if (sif.valid && sif.ready) begin
        if (sif.data !== mdata(14'(100 + got)) || sif.last !== (got == 5)) bad++;
        if (sif.last) seen_last = 1'b1;
        got++; accepted++;
      end
      @(posedge clk); #1;
    end
    chk("t3_words", got, 6); chk("t3_bad", bad, 0); chk("t3_over", over, 0);
    chk("t3_issued", issued, 6); chk("t3_last", seen_last, 1);
    sif.ready = 1'b1;
    record(4);
    chk("t3_pass", pass_count, 1); chk("t3_idle", r_busy[3], 0);

    // T4: loop mode, ten passes, then stop
    start_pass(14'd50, 14'd3, 1'b1, 1'b0);
    got = 0; bad = 0; lasts = 0; dseen = 0;
    for (int k = 0; k < 200 && lasts < 10; k++) begin
      @(negedge clk);
      if (done) dseen++;
      if (sif.valid && sif.ready) begin
        if (sif.data !== mdata(14'(50 + got % 3)) || sif.last !== (got % 3 == 2)) bad++;
        if (sif.last) lasts++;
        got++;
      end
      @(posedge clk); #1;
    end
    sif.ready = 1'b0;
    @(negedge clk);
    chk("t4_pass", pass_count, 10); chk("t4_words", got, 30); chk("t4_bad", bad, 0);
    chk("t4_nodone", dseen, 0); chk("t4_busy", busy, 1);
    @(posedge clk); #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    @(negedge clk);
    chk("t4_flush_valid", sif.valid, 0); chk("t4_flush_busy", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_idle_busy", busy, 0); chk("t4_idle_done", done, 0);
    chk("t4_idle_valid", sif.valid, 0);
    @(posedge clk); #1;
    sif.ready = 1'b1;

    // T5: empty pass, then start and stop together
    start_pass(14'd0, 14'd0, 1'b0, 1'b0);
    record(4);
    chk("t5_done0", r_done[0], 1); chk("t5_done1", r_done[1], 0);
    ncs = 0; nval = 0; nbusy = 0;
    for (int k = 0; k < 4; k++) begin
      ncs += int'(r_cs[k]); nval += int'(r_valid[k]); nbusy += int'(r_busy[k]);
    end
    chk("t5_cs", ncs, 0); chk("t5_valid", nval, 0); chk("t5_busy", nbusy, 0);
    chk("t5_pass", pass_count, 0);
    start_pass(14'd30, 14'd5, 1'b0, 1'b1);
    record(4);
    ncs = 0; nbusy = 0; ndone = 0;
    for (int k = 0; k < 4; k++) begin
      ncs += int'(r_cs[k]); nbusy += int'(r_busy[k]); ndone += int'(r_done[k]);
    end
    chk("t5_ss_cs", ncs, 0); chk("t5_ss_busy", nbusy, 0); chk("t5_ss_done", ndone, 0);

    // T6: asynchronous reset while the FIFO holds data
    sif.ready = 1'b0;
    start_pass(14'd200, 14'd8, 1'b0, 1'b0);
    record(5);
    chk("t6_pre_busy", r_busy[4], 1); chk("t6_pre_valid", r_valid[4], 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy", busy, 0); chk("t6_valid", sif.valid, 0); chk("t6_cs", mem_chipsel, 0);
    chk("t6_addr", mem_address, 0); chk("t6_data", sif.data, 0);
    chk("t6_last", sif.last, 0); chk("t6_done", done, 0); chk("t6_pass", pass_count, 0);
    @(negedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    sif.ready = 1'b1;
    start_pass(14'd20, 14'd2, 1'b0, 1'b0);
    record(8);
    chk("t6_addr0", r_addr[0], 20); chk("t6_addr1", r_addr[1], 21);
    chk("t6_data2", r_data[2], mdata(14'd20)); chk("t6_data3", r_data[3], mdata(14'd21));
    chk("t6_last2", r_last[2], 0); chk("t6_last3", r_last[3], 1);
    chk("t6_done5", r_done[5], 1); chk("t6_pass_after", pass_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
